// File: rtl/video_timing_pkg.sv
// Shared constants and types for the video timing / test pattern generator.
// Default timing is 640x480@60 with a 25 MHz pixel clock.
package video_timing_pkg;

   localparam int unsigned CNT_W = 12;

   // Default 640x480@60 raster timing
   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   // Edge length of the moving box overlay
   localparam int unsigned BOX_SIZE = 32;

   typedef enum logic [1:0] {
      PAT_RED   = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_RAMP  = 2'd3
   } pattern_e;

   // 24-bit {r,g,b} colours, in left-to-right colour bar order
   localparam logic [23:0] COL_WHITE   = 24'hffffff;
   localparam logic [23:0] COL_YELLOW  = 24'hffff00;
   localparam logic [23:0] COL_CYAN    = 24'h00ffff;
   localparam logic [23:0] COL_GREEN   = 24'h00ff00;
   localparam logic [23:0] COL_MAGENTA = 24'hff00ff;
   localparam logic [23:0] COL_RED     = 24'hff0000;
   localparam logic [23:0] COL_BLUE    = 24'h0000ff;
   localparam logic [23:0] COL_BLACK   = 24'h000000;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return COL_WHITE;
         3'd1:    return COL_YELLOW;
         3'd2:    return COL_CYAN;
         3'd3:    return COL_GREEN;
         3'd4:    return COL_MAGENTA;
         3'd5:    return COL_RED;
         3'd6:    return COL_BLUE;
         default: return COL_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Raster h/v counters plus the registered sync / data-enable / frame-start
// decode. All decoded outputs lag the counters by exactly one clock and are
// mutually aligned. pix_active is the unregistered de lookahead so the parent
// can register pixel data into the same output stage.
module video_sync_counter
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             pix_active,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             frame_start,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y
);

   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic hs_c;
   logic vs_c;
   logic fs_c;

   // Combinational decode of the current counter position
   always_comb begin
      pix_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_c       = (h_cnt >= HS_START) && (h_cnt < HS_END);
      vs_c       = (v_cnt >= VS_START) && (v_cnt < VS_END);
      fs_c       = (h_cnt == '0) && (v_cnt == '0);
   end

   // Raster position: h wraps at end of line and carries into v
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

   // Registered output stage, one cycle behind the counters
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         de          <= 1'b0;
         frame_start <= 1'b0;
         x           <= '0;
         y           <= '0;
      end else begin
         hsync       <= hs_c ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_c ? SYNC_POL : ~SYNC_POL;
         de          <= pix_active;
         frame_start <= fs_c;
         x           <= pix_active ? h_cnt : '0;
         y           <= pix_active ? v_cnt : '0;
      end
   end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Video timing and RGB test pattern generator (pixel clock domain).
// Optional feature macro: MOVING_BOX_EN adds a bouncing 32x32 white box
// overlaid on every pattern; without it no box registers exist.
module video_timing_pattern_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic             clk_low,
   input  logic             reset,
   input  logic [1:0]       pattern_sel,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic [7:0]       red,
   output logic [7:0]       green,
   output logic [7:0]       blue,
   output logic             frame_start
);

   localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             pix_active;
   logic             frame_origin;
   pattern_e         pat_q;
   pattern_e         pat_cur;
   logic [2:0]       bar_idx;
   logic [23:0]      colour_c;
   logic [23:0]      pix_c;

   video_sync_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_sync (
      .clk         (clk_low),
      .reset       (reset),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .pix_active  (pix_active),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .frame_start (frame_start),
      .x           (x),
      .y           (y)
   );

   assign frame_origin = (h_cnt == '0) && (v_cnt == '0);

   // Latch the requested pattern only at the frame origin so frames never tear
   always_ff @(posedge clk_low) begin
      if (reset) begin
         pat_q <= PAT_RED;
      end else if (frame_origin) begin
         pat_q <= pattern_e'(pattern_sel);
      end
   end

   // Pixel (0,0) already belongs to the newly selected pattern
   always_comb begin
      pat_cur = frame_origin ? pattern_e'(pattern_sel) : pat_q;
      bar_idx = 3'(h_cnt / BAR_W);
      case (pat_cur)
         PAT_RED:   colour_c = COL_RED;
         PAT_BARS:  colour_c = bar_colour(bar_idx);
         PAT_CHECK: colour_c = (h_cnt[5] ^ v_cnt[5]) ? COL_BLACK : COL_WHITE;
         default:   colour_c = {h_cnt[9:2], h_cnt[9:2], h_cnt[9:2]};
      endcase
   end

`ifdef MOVING_BOX_EN
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] BOX_XMAX = CNT_W'(H_ACTIVE - BOX_SIZE);
   localparam logic [CNT_W-1:0] BOX_YMAX = CNT_W'(V_ACTIVE - BOX_SIZE);
   localparam logic [CNT_W-1:0] BOX_SZ   = CNT_W'(BOX_SIZE);

   logic [CNT_W-1:0] box_x;
   logic [CNT_W-1:0] box_y;
   logic             box_x_dn;
   logic             box_y_dn;
   logic             in_box;

   // Step the box origin in the last blanking cycle of each frame, so the new
   // position takes effect exactly at the pixel that frame_start announces
   always_ff @(posedge clk_low) begin
      if (reset) begin
         box_x    <= '0;
         box_y    <= '0;
         box_x_dn <= 1'b0;
         box_y_dn <= 1'b0;
      end else if ((h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
         if (!box_x_dn) begin
            if (box_x == BOX_XMAX) begin
               box_x_dn <= 1'b1;
               box_x    <= box_x - CNT_W'(1);
            end else begin
               box_x    <= box_x + CNT_W'(1);
            end
         end else begin
            if (box_x == '0) begin
               box_x_dn <= 1'b0;
               box_x    <= box_x + CNT_W'(1);
            end else begin
               box_x    <= box_x - CNT_W'(1);
            end
         end
         if (!box_y_dn) begin
            if (box_y == BOX_YMAX) begin
               box_y_dn <= 1'b1;
               box_y    <= box_y - CNT_W'(1);
            end else begin
               box_y    <= box_y + CNT_W'(1);
            end
         end else begin
            if (box_y == '0) begin
               box_y_dn <= 1'b0;
               box_y    <= box_y + CNT_W'(1);
            end else begin
               box_y    <= box_y - CNT_W'(1);
            end
         end
      end
   end

   assign in_box = (h_cnt >= box_x) && (h_cnt < box_x + BOX_SZ) &&
                   (v_cnt >= box_y) && (v_cnt < box_y + BOX_SZ);
`endif

   // Apply the optional overlay on top of the selected pattern
   always_comb begin
      pix_c = colour_c;
`ifdef MOVING_BOX_EN
      if (in_box) pix_c = COL_WHITE;
`endif
   end

   // Register pixel data in the same stage as de; blanking is always black
   always_ff @(posedge clk_low) begin
      if (reset) begin
         {red, green, blue} <= '0;
      end else if (!pix_active) begin
         {red, green, blue} <= '0;
      end else begin
         {red, green, blue} <= pix_c;
      end
   end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Self-checking bench for video_timing_pattern_gen using a reduced raster
// (128x48 active, 160x57 total) so several whole frames fit in a short run.
// Expected outputs come from a position-arithmetic model: outputs after the
// k-th clock since reset release show raster position p = k-1.
module tb_video_timing_pattern_gen;

   localparam int HA = 128, HF = 8, HS = 16, HB = 8;
   localparam int VA = 48,  VF = 3, VS = 2,  VB = 4;
   localparam int HT = HA + HF + HS + HB;   // 160
   localparam int VT = VA + VF + VS + VB;   // 57
   localparam int FT = HT * VT;             // 9120

   logic        clk_low = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  pattern_sel = 2'd1;
   logic        hsync, vsync, de, frame_start;
   logic [11:0] x, y;
   logic [7:0]  red, green, blue;

   always #5 clk_low = ~clk_low;

   video_timing_pattern_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .SYNC_POL (1'b0)
   ) dut (
      .clk_low     (clk_low),
      .reset       (reset),
      .pattern_sel (pattern_sel),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .x           (x),
      .y           (y),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .frame_start (frame_start)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model state ----------------
   int unsigned edges = 0;      // clocks since reset release
   bit          rst_seen = 0;
   logic [1:0]  frame_pat [int]; // pattern selected for each frame index
   logic [23:0] bar_tab [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};

   always @(posedge clk_low) begin
      if (reset) begin
         edges = 0;
         rst_seen = 1;
         frame_pat.delete();
      end else begin
         if (edges % FT == 0) frame_pat[edges / FT] = pattern_sel;
         edges++;
      end
   end

   function automatic int bounce(input int f, input int lim);
      int m;
      m = f % (2 * lim);
      return (m <= lim) ? m : 2 * lim - m;
   endfunction

   // {hsync, vsync, de, frame_start, x, y, rgb} for raster position p
   function automatic logic [51:0] model_out(input int unsigned p, input logic [1:0] pat);
      int h, v, f, g;
      logic act, hs, vs, fs;
      logic [23:0] rgb;
      h = int'(p % HT);
      v = int'((p / HT) % VT);
      f = int'(p / FT);
      act = (h < HA) && (v < VA);
      hs = !((h >= HA + HF) && (h < HA + HF + HS));
      vs = !((v >= VA + VF) && (v < VA + VF + VS));
      fs = (h == 0) && (v == 0);
      rgb = 24'h0;
      if (act) begin
         case (pat)
            2'd0: rgb = 24'hff0000;
            2'd1: rgb = bar_tab[h / (HA / 8)];
            2'd2: rgb = ((((h / 32) + (v / 32)) % 2) == 0) ? 24'hffffff : 24'h000000;
            default: begin
               g = (h / 4) % 256;
               rgb = {8'(g), 8'(g), 8'(g)};
            end
         endcase
`ifdef MOVING_BOX_EN
         if (h >= bounce(f, HA - 32) && h < bounce(f, HA - 32) + 32 &&
             v >= bounce(f, VA - 32) && v < bounce(f, VA - 32) + 32)
            rgb = 24'hffffff;
`endif
      end
      return {hs, vs, act, fs, act ? 12'(h) : 12'd0, act ? 12'(v) : 12'd0, rgb};
   endfunction

   // ---------------- checking helpers ----------------
   int cyc = 0;
   int run_de = 0, run_hs = 0, run_vs = 0;
   int last_fs = -1;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Per-cycle comparison against the model plus interval monitors
   task automatic cycle_checks();
      logic [51:0] act_vec, exp_vec;
      int unsigned p;
      logic [1:0] pat;
      cyc++;
      if (!rst_seen) return;
      act_vec = {hsync, vsync, de, frame_start, x, y, red, green, blue};
      if (edges == 0) begin
         exp_vec = {1'b1, 1'b1, 1'b0, 1'b0, 48'h0};
      end else begin
         p = edges - 1;
         pat = frame_pat.exists(int'(p / FT)) ? frame_pat[int'(p / FT)] : 2'd0;
         exp_vec = model_out(p, pat);
      end
      checks++;
      if (act_vec !== exp_vec) begin
         errors++;
         $display("FAIL raster edges=%0d: got %h expected %h", edges, act_vec, exp_vec);
      end
      if (edges == 0) begin
         run_de = 0; run_hs = 0; run_vs = 0; last_fs = -1;
      end else begin
         if (de) run_de++;
         else if (run_de > 0) begin check_val("de_width", run_de, 128); run_de = 0; end
         if (!hsync) run_hs++;
         else if (run_hs > 0) begin check_val("hsync_width", run_hs, 16); run_hs = 0; end
         if (!vsync) run_vs++;
         else if (run_vs > 0) begin check_val("vsync_cycles", run_vs, 320); run_vs = 0; end
         if (frame_start) begin
            if (last_fs >= 0) check_val("frame_period", cyc - last_fs, 9120);
            last_fs = cyc;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk_low);
      cycle_checks();
   endtask

   task automatic wait_xy(input int px, input int py, output bit ok);
      int n;
      n = 0;
      ok = 1;
      while (!(de === 1'b1 && x == 12'(px) && y == 12'(py))) begin
         if (n >= 2 * FT) begin ok = 0; return; end
         tick();
         n++;
      end
   endtask

   task automatic check_pixel(input int px, input int py, input logic [23:0] want, input string name);
      bit ok;
      wait_xy(px, py, ok);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: pixel (%0d,%0d) never reached, required rgb %h", name, px, py, want);
      end else begin
         check_val(name, {red, green, blue}, want);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit ok;
      int nrst;
      reset = 1'b1;
      pattern_sel = 2'd1;
      repeat (3) tick();
      check_val("reset_hsync", hsync, 1);
      check_val("reset_vsync", vsync, 1);
      check_val("reset_de", de, 0);
      check_val("reset_fs", frame_start, 0);
      check_val("reset_rgb", {red, green, blue}, 0);

      reset = 1'b0;
      tick();
      check_val("start_fs", frame_start, 1);
      check_val("start_xy", {x, y}, 0);

      // colour bars, bar width 16
      check_pixel(0, 0, 24'hffffff, "bars_x0");
      check_pixel(16, 0, 24'hffff00, "bars_x16");
      check_pixel(80, 5, 24'hff0000, "bars_x80");
      check_pixel(127, 5, 24'h000000, "bars_x127");
      tick();
      check_val("blank_rgb", {red, green, blue}, 0);
      check_val("blank_de", de, 0);

      // pattern change mid-frame must wait for the next frame
      check_pixel(0, 10, 24'hffffff, "bars_l10");
      pattern_sel = 2'd2;
      check_pixel(80, 11, 24'hff0000, "no_tear_l11");
      check_pixel(0, 0, 24'hffffff, "chk_0_0");
      check_pixel(32, 0, 24'h000000, "chk_32_0");
      check_pixel(0, 32, 24'h000000, "chk_0_32");
      check_pixel(32, 32, 24'hffffff, "chk_32_32");

      pattern_sel = 2'd3;
      check_pixel(100, 3, 24'h191919, "ramp_x100");
      pattern_sel = 2'd0;
      check_pixel(5, 5, 24'h010101, "ramp_no_tear");
      check_pixel(0, 0, 24'hff0000, "red_0_0");

      // randomized pattern changes, checked by the per-cycle model compare
      repeat (6) begin
         repeat ($urandom_range(500, 2500)) tick();
         pattern_sel = 2'($urandom_range(0, 3));
      end

      // reset in the middle of a line and frame
      wait_xy(60, 20, ok);
      check_val("reach_60_20", 32'(ok), 1);
      reset = 1'b1;
      nrst = $urandom_range(1, 3);
      repeat (nrst) tick();
      check_val("midrst_de", de, 0);
      check_val("midrst_xy", {x, y}, 0);
      check_val("midrst_rgb", {red, green, blue}, 0);
      check_val("midrst_hsync", hsync, 1);
      reset = 1'b0;
      tick();
      check_val("midrst_fs", frame_start, 1);
      check_val("midrst_de_start", de, 1);

      repeat (FT + 2 * HT) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
